sig_cmp_multi: RTL and testbench
================================

// Module: sig_cmp_multi
// PURPOSE
//  Multi-channel LBIST signature comparator. On start, it snapshots NCH MISR signatures
//  and NCH golden signatures, then compares them one channel per clock.
//  Reports pass/fail, a per-channel fail mask, a sticky fail flag and a saturating
//  count of failing sessions. Sits between the MISR bank and the BIST controller/status regs.
// PARAMETERS
//  RC_BITS  8  width of one signature (MISR length)
//  NCH      4  number of signature channels (>=1)
//  CNT_W    8  width of failing-session counter
// PORTS
//  clk          in   1            rising-edge clock
//  rst          in   1            async reset, active-high
//  start        in   1            1-cycle request; accepted only when busy=0
//  sig          in   NCH*RC_BITS  MISR signatures; ch i = sig[i*RC_BITS +: RC_BITS]
//  gold         in   NCH*RC_BITS  golden signatures; same packing
//  clr_sticky   in   1            clears sticky_fail
//  busy         out  1            session in progress
//  done         out  1            1-cycle pulse: results valid
//  res          out  1            1 = all channels matched in last session
//  fail_mask    out  NCH          bit i = channel i mismatched in last session
//  sticky_fail  out  1            set by any failing session; held until clr_sticky
//  mismatch_cnt out  CNT_W        count of failing sessions; saturates at all-ones
// BEHAVIOUR
//  - Reset (async, any state): FSM=IDLE; all outputs 0; idx=0; snapshots 0.
//  - FSM IDLE -> CMP -> DONE -> IDLE. Encoding: IDLE=0, CMP=1, DONE=2.
//  - IDLE: on start=1, register sig/gold into snapshot regs, clear working mask, idx=0, go CMP.
//  - CMP: compare snapshot lane idx (full RC_BITS equality). Set mask[idx] on mismatch.
//    If idx==NCH-1, go DONE; else idx+1. Lane compare is combinational; the mask is registered.
//  - DONE (one cycle): done=1.
//    - Copy working mask to fail_mask.
//    - res = ~|mask.
//    - If |mask: sticky_fail<=1 and mismatch_cnt<=cnt+1, unless the counter is all-ones.
//    - Next state IDLE.
//  - busy=1 in CMP and DONE. Latency: start sampled at edge k -> done high for cycle k+NCH+1.
//  - start while busy=1 is ignored (no queueing). start in the same cycle as done is ignored.
//  - Inputs sig/gold may change after start; only the snapshots are compared.
//  - res/fail_mask hold last-session values until the next DONE. They are 0 after reset.
//  - clr_sticky in the same cycle as a failing DONE: set wins (sticky_fail=1).
//  - clr_sticky does not touch mismatch_cnt. Only rst clears it.
//  - Reset mid-session aborts: no done pulse, counters/flags 0.
//  - NCH=1: a single CMP cycle; idx stays 0 (index width max(1,clog2(NCH))).
// CONFIGURATION
//  SIG_CMP_DIAG_EN defined: adds outputs diag_valid(1), diag_ch(clog2 NCH), diag_sig(RC_BITS).
//    - Captures the first mismatching channel index and its snapshot signature in the
//      first failing session since reset/clr_sticky.
//    - Held until clr_sticky (clr has priority only when there is no failing DONE that cycle).
//    - diag_valid mirrors "capture held". Outputs reset to 0.
//  Not defined: ports and logic absent. Behaviour is otherwise identical.
// STRUCTURE
//  - Package lbist_cmp_pkg: FSM state localparams (IDLE/CMP/DONE) and a clog2 helper function.
//  - Sub-module sig_lane_eq: one RC_BITS equality lane.
//    - Instanced once and fed by a mux on idx over the snapshots.
//    - Output is mismatch = |(a^b).
// TESTING (RC_BITS=8, NCH=4, CNT_W=8)
//  1. sig=gold=32'hFCFCFCFC, start -> done at start+5, res=1, fail_mask=0, sticky=0, cnt=0.
//  2. gold=32'hFCFCFCFC, sig=32'hFFFCFCFC -> res=0, fail_mask=4'b1000, sticky=1, cnt=1;
//     diag(if EN): ch=3, sig=8'hFF.
//  3. Snapshot check: change sig to a mismatch 1 cycle after start on matching data -> res=1.
//     start pulsed while busy -> ignored, only one done.
//  4. 255 failing sessions, then 1 more -> cnt stays 8'hFF.
//     clr_sticky with a failing DONE -> sticky=1; clr alone -> sticky=0, cnt unchanged.
//  5. Assert rst during CMP (idx=2) -> all outputs 0 immediately, no done.
//     Next start completes normally.

Source files
------------

// File: rtl/lbist_cmp_pkg.sv
// Shared definitions for the LBIST signature comparator.
//   state_e   : comparator FSM states (IDLE=0, CMP=1, DONE=2)
//   clog2     : ceil(log2(n)) for parameter arithmetic
//   idx_width : width of a channel index, never narrower than one bit
package lbist_cmp_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCmp  = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(n)) begin
            r++;
        end
        return r;
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sig_lane_eq.sv
// One signature equality lane.
//   a_i, b_i   : RC_BITS-wide signatures to compare
//   mismatch_o : 1 when any bit differs
module sig_lane_eq #(
    parameter int unsigned RC_BITS = 8
) (
    input  logic [RC_BITS-1:0] a_i,
    input  logic [RC_BITS-1:0] b_i,
    output logic               mismatch_o
);

    assign mismatch_o = |(a_i ^ b_i);

endmodule

// File: rtl/sig_cmp_multi.sv
// Multi-channel LBIST signature comparator.
// A start snapshots NCH MISR signatures and NCH golden signatures, then one channel
// is compared per clock. The session result is published together with a 1-cycle
// done pulse. A sticky fail flag and a saturating count of failing sessions are
// also kept.
//   clk, rst       : clock, asynchronous active-high reset
//   start          : session request, taken only when idle
//   sig, gold      : packed signatures, channel i = [i*RC_BITS +: RC_BITS]
//   clr_sticky     : clears sticky_fail (a failing session in the same cycle wins)
//   busy           : session in progress
//   done           : 1-cycle pulse, results below are valid
//   res            : 1 = every channel matched in the last session
//   fail_mask      : per-channel mismatch of the last session
//   sticky_fail    : set by any failing session, held until clr_sticky
//   mismatch_cnt   : failing-session count, saturates at all-ones
// Optional (macro SIG_CMP_DIAG_EN):
//   diag_valid, diag_ch, diag_sig : first mismatching channel and its snapshot
//   signature from the first failing session since reset / clr_sticky.
module sig_cmp_multi
    import lbist_cmp_pkg::*;
#(
    parameter int unsigned RC_BITS = 8,
    parameter int unsigned NCH     = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [NCH*RC_BITS-1:0]        sig,
    input  logic [NCH*RC_BITS-1:0]        gold,
    input  logic                          clr_sticky,
    output logic                          busy,
    output logic                          done,
    output logic                          res,
    output logic [NCH-1:0]                fail_mask,
    output logic                          sticky_fail,
`ifdef SIG_CMP_DIAG_EN
    output logic                          diag_valid,
    output logic [idx_width(NCH)-1:0]     diag_ch,
    output logic [RC_BITS-1:0]            diag_sig,
`endif
    output logic [CNT_W-1:0]              mismatch_cnt
);

    localparam int unsigned IDX_W = idx_width(NCH);
    localparam int unsigned SIG_W = NCH * RC_BITS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

    state_e             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [SIG_W-1:0]   sig_snap_q;
    logic [SIG_W-1:0]   gold_snap_q;
    logic [NCH-1:0]     mask_q;
    logic               busy_q;
    logic               done_q;
    logic               res_q;
    logic [NCH-1:0]     fail_mask_q;
    logic               sticky_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [RC_BITS-1:0] lane_sig;
    logic [RC_BITS-1:0] lane_gold;
    logic               lane_mismatch;
    logic               sess_fail;

    // Select the snapshot lane under test.
    always_comb begin
        lane_sig  = '0;
        lane_gold = '0;
        for (int i = 0; i < int'(NCH); i++) begin
            if (idx_q == IDX_W'(i)) begin
                lane_sig  = sig_snap_q[i*RC_BITS +: RC_BITS];
                lane_gold = gold_snap_q[i*RC_BITS +: RC_BITS];
            end
        end
    end

    sig_lane_eq #(
        .RC_BITS (RC_BITS)
    ) u_lane_eq (
        .a_i        (lane_sig),
        .b_i        (lane_gold),
        .mismatch_o (lane_mismatch)
    );

    assign sess_fail = (state_q == StDone) && (|mask_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            sig_snap_q  <= '0;
            gold_snap_q <= '0;
            mask_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            res_q       <= 1'b0;
            fail_mask_q <= '0;
            sticky_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            done_q <= 1'b0;

            // A failing session outranks a simultaneous clear.
            if (sess_fail) begin
                sticky_q <= 1'b1;
            end else if (clr_sticky) begin
                sticky_q <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    // The done cycle is still IDLE in state terms; a start there is dropped.
                    if (start && !done_q) begin
                        sig_snap_q  <= sig;
                        gold_snap_q <= gold;
                        mask_q      <= '0;
                        idx_q       <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= StCmp;
                    end
                end
                StCmp: begin
                    mask_q <= mask_q | (NCH'(lane_mismatch) << idx_q);
                    if (idx_q == LAST_IDX) begin
                        state_q <= StDone;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                StDone: begin
                    done_q      <= 1'b1;
                    res_q       <= ~|mask_q;
                    fail_mask_q <= mask_q;
                    if (sess_fail && (cnt_q != {CNT_W{1'b1}})) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign res          = res_q;
    assign fail_mask    = fail_mask_q;
    assign sticky_fail  = sticky_q;
    assign mismatch_cnt = cnt_q;

`ifdef SIG_CMP_DIAG_EN
    logic               diag_valid_q;
    logic [IDX_W-1:0]   diag_ch_q;
    logic [RC_BITS-1:0] diag_sig_q;
    logic [IDX_W-1:0]   first_ch;
    logic [RC_BITS-1:0] first_sig;

    // Lowest-numbered failing channel of the working mask.
    always_comb begin
        first_ch  = '0;
        first_sig = '0;
        for (int i = int'(NCH) - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                first_ch  = IDX_W'(i);
                first_sig = sig_snap_q[i*RC_BITS +: RC_BITS];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diag_valid_q <= 1'b0;
            diag_ch_q    <= '0;
            diag_sig_q   <= '0;
        end else if (sess_fail) begin
            if (!diag_valid_q) begin
                diag_valid_q <= 1'b1;
                diag_ch_q    <= first_ch;
                diag_sig_q   <= first_sig;
            end
        end else if (clr_sticky) begin
            diag_valid_q <= 1'b0;
            diag_ch_q    <= '0;
            diag_sig_q   <= '0;
        end
    end

    assign diag_valid = diag_valid_q;
    assign diag_ch    = diag_ch_q;
    assign diag_sig   = diag_sig_q;
`endif

endmodule

// File: tb/tb_sig_cmp_multi.sv
// Bench for sig_cmp_multi (RC_BITS=8, NCH=4, CNT_W=8). Sessions are issued with
// fixed timing; the expected result of each session is pushed to a queue and a
// monitor pops and compares whenever done is seen.
module tb_sig_cmp_multi;

    localparam int RC_BITS = 8;
    localparam int NCH     = 4;
    localparam int CNT_W   = 8;
    localparam int W       = NCH * RC_BITS;

    logic             clk;
    logic             rst;
    logic             start;
    logic [W-1:0]     sig;
    logic [W-1:0]     gold;
    logic             clr_sticky;
    logic             busy;
    logic             done;
    logic             res;
    logic [NCH-1:0]   fail_mask;
    logic             sticky_fail;
    logic [CNT_W-1:0] mismatch_cnt;
`ifdef SIG_CMP_DIAG_EN
    logic             diag_valid;
    logic [1:0]       diag_ch;
    logic [7:0]       diag_sig;
`endif

    sig_cmp_multi #(
        .RC_BITS (RC_BITS),
        .NCH     (NCH),
        .CNT_W   (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .sig          (sig),
        .gold         (gold),
        .clr_sticky   (clr_sticky),
        .busy         (busy),
        .done         (done),
        .res          (res),
        .fail_mask    (fail_mask),
        .sticky_fail  (sticky_fail),
`ifdef SIG_CMP_DIAG_EN
        .diag_valid   (diag_valid),
        .diag_ch      (diag_ch),
        .diag_sig     (diag_sig),
`endif
        .mismatch_cnt (mismatch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit           res;
        bit [NCH-1:0] mask;
        bit           sticky;
        int           cnt;
        bit           dv;
        int           dch;
        int           dsig;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Model state carried between sessions.
    bit m_sticky = 0;
    int m_cnt    = 0;
    bit m_dv     = 0;
    int m_dch    = 0;
    int m_dsig   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic int lane_of(input logic [W-1:0] v, input int ch);
        return int'((v >> (ch * RC_BITS)) % 256);
    endfunction

    // Expected outcome of a session, plus model update.
    function automatic exp_t model_session(input logic [W-1:0] s, input logic [W-1:0] g,
                                           input bit clr_done);
        exp_t e;
        bit   first_found;
        e.mask = '0;
        first_found = 0;
        for (int i = 0; i < NCH; i++) begin
            if (lane_of(s, i) != lane_of(g, i)) begin
                e.mask[i] = 1'b1;
                if (!first_found && !m_dv) begin
                    m_dch  = i;
                    m_dsig = lane_of(s, i);
                end
                first_found = 1;
            end
        end
        e.res = (e.mask == 0);
        if (!e.res) begin
            m_sticky = 1;
            if (m_cnt < 255) m_cnt = m_cnt + 1;
            m_dv = 1;
        end else if (clr_done) begin
            m_sticky = 0;
            m_dv = 0; m_dch = 0; m_dsig = 0;
        end
        e.sticky = m_sticky;
        e.cnt    = m_cnt;
        e.dv     = m_dv;
        e.dch    = m_dch;
        e.dsig   = m_dsig;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("res", res, e.res);
                chk("fail_mask", fail_mask, e.mask);
                chk("sticky_fail", sticky_fail, e.sticky);
                chk("mismatch_cnt", mismatch_cnt, e.cnt);
`ifdef SIG_CMP_DIAG_EN
                chk("diag_valid", diag_valid, e.dv);
                chk("diag_ch", diag_ch, e.dch);
                chk("diag_sig", diag_sig, e.dsig);
`endif
            end
        end
    end

    // One session: start sampled at edge k, done expected right after edge k+NCH+1.
    task automatic run_session(input logic [W-1:0] s, input logic [W-1:0] g,
                               input bit clr_done, input bit mutate,
                               input bit extra_start, input bit start_in_done);
        exp_q.push_back(model_session(s, g, clr_done));
        @(negedge clk);
        sig   = s;
        gold  = g;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        if (mutate) sig = ~s;
        for (int c = 0; c < NCH; c++) begin
            @(posedge clk);
            #1;
            start = (extra_start && c == 0);
        end
        chk("done_early", done, 0);
        clr_sticky = clr_done;
        @(posedge clk);
        #1;
        clr_sticky = 1'b0;
        chk("done_latency", done, 1);
        start = start_in_done;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("idle_after_done", busy, 0);
    endtask

    task automatic clr_alone();
        @(negedge clk);
        clr_sticky = 1'b1;
        @(posedge clk);
        #1;
        clr_sticky = 1'b0;
        m_sticky = 0;
        m_dv = 0; m_dch = 0; m_dsig = 0;
        chk("clr_sticky_flag", sticky_fail, 0);
        chk("clr_keeps_cnt", mismatch_cnt, m_cnt);
    endtask

    function automatic logic [W-1:0] rand_err(input logic [W-1:0] g);
        logic [W-1:0] s;
        s = g;
        for (int i = 0; i < NCH; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                s = s ^ (W'($urandom_range(1, 255)) << (i * RC_BITS));
            end
        end
        return s;
    endfunction

    initial begin
        logic [W-1:0] g;
        rst = 1'b1;
        start = 1'b0;
        sig = '0;
        gold = '0;
        clr_sticky = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_res", res, 0);
        chk("rst_mask", fail_mask, 0);
        chk("rst_sticky", sticky_fail, 0);
        chk("rst_cnt", mismatch_cnt, 0);
        @(negedge clk);
        rst = 1'b0;

        // Matching, then a single-channel mismatch on channel 3.
        run_session(32'hFCFC_FCFC, 32'hFCFC_FCFC, 0, 0, 0, 0);
        run_session(32'hFFFC_FCFC, 32'hFCFC_FCFC, 0, 0, 0, 0);
        // Snapshot isolation, start while busy, start in the done cycle.
        run_session(32'h1234_5678, 32'h1234_5678, 0, 1, 1, 1);
        clr_alone();

        // Randomized sessions.
        for (int n = 0; n < 24; n++) begin
            g = W'($urandom);
            run_session(rand_err(g), g, bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 1)),
                        bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) clr_alone();
        end

        // Counter saturation.
        for (int n = 0; n < 256; n++) begin
            g = W'($urandom);
            run_session(~g, g, 0, 0, 0, 0);
        end
        chk("cnt_saturated", mismatch_cnt, 8'hFF);
        run_session(32'h0000_00AA, 32'h0000_0055, 1, 0, 0, 0);
        clr_alone();

        // Reset while comparing channel 2.
        run_session(32'h0011_0000, 32'h0000_0000, 0, 0, 0, 0);
        @(negedge clk);
        sig   = 32'hDEAD_BEEF;
        gold  = 32'h0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_res", res, 0);
        chk("abort_mask", fail_mask, 0);
        chk("abort_sticky", sticky_fail, 0);
        chk("abort_cnt", mismatch_cnt, 0);
        m_sticky = 0; m_cnt = 0; m_dv = 0; m_dch = 0; m_dsig = 0;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        run_session(32'h0100_0000, 32'h0000_0000, 0, 0, 0, 0);
        run_session(32'h5A5A_5A5A, 32'h5A5A_5A5A, 0, 0, 0, 0);

        repeat (10) @(posedge clk);
        #1;
        chk("outstanding_sessions", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
